// File: rtl/msrv32_lsu_ctrl_if.sv
// Data-bus bundle between the load/store controller (master) and the
// memory side (slave). A single request/acknowledge handshake per access.
interface msrv32_lsu_ctrl_if;
  logic        dbus_req_out;
  logic        dbus_we_out;
  logic [31:0] dbus_addr_out;
  logic [31:0] dbus_wdata_out;
  logic [3:0]  dbus_wmask_out;
  logic        dbus_ack_in;
  logic [31:0] dbus_rdata_in;

  modport master (
    output dbus_req_out,
    output dbus_we_out,
    output dbus_addr_out,
    output dbus_wdata_out,
    output dbus_wmask_out,
    input  dbus_ack_in,
    input  dbus_rdata_in
  );

  modport slave (
    input  dbus_req_out,
    input  dbus_we_out,
    input  dbus_addr_out,
    input  dbus_wdata_out,
    input  dbus_wmask_out,
    output dbus_ack_in,
    output dbus_rdata_in
  );
endinterface

// File: rtl/msrv32_lsu_ctrl.sv
// Load/store bus controller sitting after the decode->execute register.
// Issues one request/acknowledge transaction per load or store, stalls the
// pipeline while it is outstanding, and returns aligned, extended load data.
// Optional macro MSRV32_DBUS_TIMEOUT_EN: abort a request that waits
// TIMEOUT_CYCLES without ack and pulse bus_err_out. Without it, a request
// waits forever and bus_err_out is constant 0.
module msrv32_lsu_ctrl #(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int CNT_W          = 9
) (
  input  logic                     clk_in,
  input  logic                     reset_in,
  input  logic                     ld_req_in,
  input  logic                     st_req_in,
  input  logic [31:0]              addr_in,
  input  logic [31:0]              st_data_in,
  input  logic [1:0]               size_in,
  input  logic                     load_unsigned_in,
  msrv32_lsu_ctrl_if.master        dbus,
  output logic                     stall_out,
  output logic [31:0]              load_data_out,
  output logic                     load_valid_out,
  output logic                     misaligned_out,
  output logic                     bus_err_out
);

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_t;

  // Replicate store data across every byte lane it may land in.
  function automatic logic [31:0] store_lanes(input logic [1:0]  size,
                                              input logic [31:0] data);
    logic [31:0] lanes;
    case (size)
      2'b00:   lanes = {4{data[7:0]}};
      2'b01:   lanes = {2{data[15:0]}};
      default: lanes = data;
    endcase
    return lanes;
  endfunction

  // Byte-lane write enables for the addressed bytes.
  function automatic logic [3:0] store_mask(input logic [1:0] size,
                                            input logic [1:0] off);
    logic [3:0] mask;
    case (size)
      2'b00:   mask = 4'b0001 << off;
      2'b01:   mask = 4'b0011 << off;
      default: mask = 4'b1111;
    endcase
    return mask;
  endfunction

  // Pull the addressed lane out of the read word and sign/zero-extend it.
  function automatic logic [31:0] load_extend(input logic [31:0] rdata,
                                              input logic [1:0]  off,
                                              input logic [1:0]  size,
                                              input logic        uns);
    logic [31:0]        shifted;
    logic signed [7:0]  byte_s;
    logic signed [15:0] half_s;
    logic signed [31:0] ext_s;
    logic [31:0]        result;
    shifted = rdata >> {off, 3'b000};
    byte_s  = shifted[7:0];
    half_s  = shifted[15:0];
    case (size)
      2'b00: begin
        ext_s  = byte_s;
        result = uns ? {24'h000000, shifted[7:0]} : ext_s;
      end
      2'b01: begin
        ext_s  = half_s;
        result = uns ? {16'h0000, shifted[15:0]} : ext_s;
      end
      default: begin
        ext_s  = '0;
        result = rdata;
      end
    endcase
    return result;
  endfunction

  // Registered state (_p1) and its next value (_p0)
  state_t      state_p0, state_p1;
  logic        req_p0, req_p1;
  logic        we_p0, we_p1;
  logic [31:0] addr_p0, addr_p1;
  logic [31:0] wdata_p0, wdata_p1;
  logic [3:0]  wmask_p0, wmask_p1;
  logic [1:0]  off_p0, off_p1;
  logic [1:0]  size_p0, size_p1;
  logic        uns_p0, uns_p1;
  logic        is_ld_p0, is_ld_p1;
  logic [31:0] ldata_p0, ldata_p1;
  logic        vld_p0, vld_p1;
  logic        mis_p0, mis_p1;

`ifdef MSRV32_DBUS_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_p0, cnt_p1;
  logic             err_p0, err_p1;
`endif

  logic req_any;
  logic misaligned;

  assign req_any    = ld_req_in | st_req_in;
  assign misaligned = ((size_in == 2'b01) && addr_in[0]) ||
                      (size_in[1] && (addr_in[1:0] != 2'b00));

  // Next-state and next-output logic for the IDLE/REQ controller.
  always_comb begin
    state_p0 = state_p1;
    req_p0   = req_p1;
    we_p0    = we_p1;
    addr_p0  = addr_p1;
    wdata_p0 = wdata_p1;
    wmask_p0 = wmask_p1;
    off_p0   = off_p1;
    size_p0  = size_p1;
    uns_p0   = uns_p1;
    is_ld_p0 = is_ld_p1;
    ldata_p0 = ldata_p1;
    vld_p0   = 1'b0;
    mis_p0   = 1'b0;
`ifdef MSRV32_DBUS_TIMEOUT_EN
    cnt_p0   = cnt_p1;
    err_p0   = 1'b0;
`endif
    case (state_p1)
      IDLE: begin
        if (req_any) begin
          if (misaligned) begin
            mis_p0 = 1'b1;
          end else begin
            // A simultaneous load+store request is handled as a store.
            state_p0 = REQ;
            req_p0   = 1'b1;
            we_p0    = st_req_in;
            addr_p0  = {addr_in[31:2], 2'b00};
            wdata_p0 = st_req_in ? store_lanes(size_in, st_data_in) : 32'h0;
            wmask_p0 = st_req_in ? store_mask(size_in, addr_in[1:0]) : 4'b0000;
            off_p0   = addr_in[1:0];
            size_p0  = size_in;
            uns_p0   = load_unsigned_in;
            is_ld_p0 = ~st_req_in;
`ifdef MSRV32_DBUS_TIMEOUT_EN
            cnt_p0   = '0;
`endif
          end
        end
      end
      REQ: begin
        if (dbus.dbus_ack_in) begin
          state_p0 = IDLE;
          req_p0   = 1'b0;
          if (is_ld_p1) begin
            vld_p0   = 1'b1;
            ldata_p0 = load_extend(dbus.dbus_rdata_in, off_p1, size_p1, uns_p1);
          end
        end
`ifdef MSRV32_DBUS_TIMEOUT_EN
        else begin
          cnt_p0 = cnt_p1 + 1'b1;
          if (cnt_p0 == CNT_W'(TIMEOUT_CYCLES)) begin
            state_p0 = IDLE;
            req_p0   = 1'b0;
            err_p0   = 1'b1;
          end
        end
`endif
      end
      default: state_p0 = IDLE;
    endcase
  end

  // State and registered-output update; active-low synchronous reset.
  always_ff @(posedge clk_in) begin
    if (!reset_in) begin
      state_p1 <= IDLE;
      req_p1   <= 1'b0;
      we_p1    <= 1'b0;
      addr_p1  <= '0;
      wdata_p1 <= '0;
      wmask_p1 <= '0;
      off_p1   <= '0;
      size_p1  <= '0;
      uns_p1   <= 1'b0;
      is_ld_p1 <= 1'b0;
      ldata_p1 <= '0;
      vld_p1   <= 1'b0;
      mis_p1   <= 1'b0;
`ifdef MSRV32_DBUS_TIMEOUT_EN
      cnt_p1   <= '0;
      err_p1   <= 1'b0;
`endif
    end else begin
      state_p1 <= state_p0;
      req_p1   <= req_p0;
      we_p1    <= we_p0;
      addr_p1  <= addr_p0;
      wdata_p1 <= wdata_p0;
      wmask_p1 <= wmask_p0;
      off_p1   <= off_p0;
      size_p1  <= size_p0;
      uns_p1   <= uns_p0;
      is_ld_p1 <= is_ld_p0;
      ldata_p1 <= ldata_p0;
      vld_p1   <= vld_p0;
      mis_p1   <= mis_p0;
`ifdef MSRV32_DBUS_TIMEOUT_EN
      cnt_p1   <= cnt_p0;
      err_p1   <= err_p0;
`endif
    end
  end

  // Stall covers the accept cycle and every REQ cycle until the ack arrives.
  assign stall_out = ((state_p1 == IDLE) && req_any && !misaligned) ||
                     ((state_p1 == REQ) && !dbus.dbus_ack_in);

  assign dbus.dbus_req_out   = req_p1;
  assign dbus.dbus_we_out    = we_p1;
  assign dbus.dbus_addr_out  = addr_p1;
  assign dbus.dbus_wdata_out = wdata_p1;
  assign dbus.dbus_wmask_out = wmask_p1;
  assign load_data_out       = ldata_p1;
  assign load_valid_out      = vld_p1;
  assign misaligned_out      = mis_p1;

`ifdef MSRV32_DBUS_TIMEOUT_EN
  assign bus_err_out = err_p1;
`else
  // Timeout parameters only matter when the abort logic is built.
  logic [CNT_W-1:0] unused_timeout;
  assign unused_timeout = CNT_W'(TIMEOUT_CYCLES);
  assign bus_err_out    = 1'b0;
`endif

endmodule

// File: tb/tb_msrv32_lsu_ctrl.sv
// Self-checking bench for msrv32_lsu_ctrl: directed test-plan cases plus
// randomized loads/stores against a byte-arithmetic reference model.
module tb_msrv32_lsu_ctrl;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        ld_req = 1'b0;
  logic        st_req = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] st_data = '0;
  logic [1:0]  size = '0;
  logic        luns = 1'b0;
  logic        stall;
  logic [31:0] load_data;
  logic        lvalid;
  logic        misal;
  logic        bus_err;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] last_load = '0;

  msrv32_lsu_ctrl_if bus ();

  msrv32_lsu_ctrl #(.TIMEOUT_CYCLES(TO), .CNT_W(9)) dut (
    .clk_in           (clk),
    .reset_in         (reset_n),
    .ld_req_in        (ld_req),
    .st_req_in        (st_req),
    .addr_in          (addr),
    .st_data_in       (st_data),
    .size_in          (size),
    .load_unsigned_in (luns),
    .dbus             (bus),
    .stall_out        (stall),
    .load_data_out    (load_data),
    .load_valid_out   (lvalid),
    .misaligned_out   (misal),
    .bus_err_out      (bus_err)
  );

  always #5 clk = ~clk;

  initial begin
    bus.dbus_ack_in   = 1'b0;
    bus.dbus_rdata_in = '0;
  end

  // ---------------- reference model ----------------
  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic bit ref_misaligned(input logic [31:0] a, input logic [1:0] sz);
    return (a % nbytes(sz)) != 0;
  endfunction

  function automatic logic [3:0] ref_mask(input logic [31:0] a, input logic [1:0] sz);
    int m;
    m = ((1 << nbytes(sz)) - 1) << (a % 4);
    return m[3:0];
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [31:0] d, input logic [1:0] sz);
    logic [31:0] w;
    int nb;
    nb = nbytes(sz);
    for (int i = 0; i < 4; i++) w[8*i +: 8] = d[8*(i % nb) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] rd, input logic [31:0] a,
                                           input logic [1:0] sz, input logic uns);
    logic [63:0] v;
    int nb;
    nb = nbytes(sz);
    v = ({32'h0, rd} >> (8 * (a % 4))) & ((64'd1 << (8 * nb)) - 64'd1);
    if (!uns && nb < 4 && v[8*nb-1]) v = v - (64'd1 << (8 * nb));
    return v[31:0];
  endfunction

  // One full access: request in cycle 0, ack in cycle lat, result in lat+1.
  task automatic do_txn(input string tag, input logic ld, input logic st,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [1:0] sz, input logic uns,
                        input int lat, input logic [31:0] rd);
    bit mis;
    bit is_st;
    logic [3:0]  em;
    logic [31:0] ew;
    mis   = ref_misaligned(a, sz);
    is_st = st;
    em    = is_st ? ref_mask(a, sz) : 4'b0000;
    ew    = ref_wdata(d, sz);
    @(posedge clk); #1;
    ld_req = ld; st_req = st; addr = a; st_data = d; size = sz; luns = uns;
    bus.dbus_ack_in = 1'b0; bus.dbus_rdata_in = $urandom;
    #1;
    n_tests++;
    if (stall !== (!mis && (ld || st)) || bus.dbus_req_out !== 1'b0) begin
      n_fail++;
      $display("FAIL %s c0 stall/req: got %b/%b exp %b/0", tag, stall, bus.dbus_req_out, !mis);
    end
    if (mis) begin
      @(posedge clk); #1;
      ld_req = 1'b0; st_req = 1'b0;
      #1;
      n_tests++;
      if ({misal, bus.dbus_req_out, stall, lvalid} !== 4'b1000) begin
        n_fail++;
        $display("FAIL %s misaligned mis/req/stall/vld: got %b exp 1000", tag,
                 {misal, bus.dbus_req_out, stall, lvalid});
      end
      @(posedge clk); #2;
      n_tests++;
      if (misal !== 1'b0 || bus.dbus_req_out !== 1'b0) begin
        n_fail++;
        $display("FAIL %s misaligned pulse width: mis=%b req=%b exp 0/0", tag, misal, bus.dbus_req_out);
      end
      return;
    end
    for (int j = 1; j <= lat; j++) begin
      @(posedge clk); #1;
      ld_req = 1'b0; st_req = 1'b0;
      addr = $urandom; st_data = $urandom; size = 2'($urandom); luns = 1'($urandom);
      bus.dbus_ack_in   = (j == lat);
      bus.dbus_rdata_in = (j == lat) ? rd : $urandom;
      #1;
      n_tests++;
      if (bus.dbus_req_out !== 1'b1 || bus.dbus_we_out !== is_st ||
          bus.dbus_addr_out !== (a & 32'hFFFF_FFFC)) begin
        n_fail++;
        $display("FAIL %s c%0d req/we/addr: got %b/%b/%h exp 1/%b/%h", tag, j,
                 bus.dbus_req_out, bus.dbus_we_out, bus.dbus_addr_out, is_st, a & 32'hFFFF_FFFC);
      end
      n_tests++;
      if (bus.dbus_wmask_out !== em || (is_st && bus.dbus_wdata_out !== ew)) begin
        n_fail++;
        $display("FAIL %s c%0d wmask/wdata: got %b/%h exp %b/%h", tag, j,
                 bus.dbus_wmask_out, bus.dbus_wdata_out, em, ew);
      end
      n_tests++;
      if (stall !== (j != lat) || lvalid !== 1'b0) begin
        n_fail++;
        $display("FAIL %s c%0d stall/vld: got %b/%b exp %b/0", tag, j, stall, lvalid, j != lat);
      end
    end
    @(posedge clk); #1;
    bus.dbus_ack_in = 1'b0; bus.dbus_rdata_in = $urandom;
    #1;
    if (!is_st) last_load = ref_load(rd, a, sz, uns);
    n_tests++;
    if (bus.dbus_req_out !== 1'b0 || stall !== 1'b0 || lvalid !== !is_st) begin
      n_fail++;
      $display("FAIL %s done req/stall/vld: got %b/%b/%b exp 0/0/%b", tag,
               bus.dbus_req_out, stall, lvalid, !is_st);
    end
    n_tests++;
    if (load_data !== last_load) begin
      n_fail++;
      $display("FAIL %s load_data: got %h exp %h", tag, load_data, last_load);
    end
    n_tests++;
    if (misal !== 1'b0 || bus_err !== 1'b0) begin
      n_fail++;
      $display("FAIL %s done mis/err: got %b/%b exp 0/0", tag, misal, bus_err);
    end
    @(posedge clk); #2;
    n_tests++;
    if (lvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s load_valid width: got %b exp 0", tag, lvalid);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    n_tests++;
    if ({bus.dbus_req_out, bus.dbus_we_out, bus.dbus_wmask_out, lvalid, misal, bus_err, stall} !== 10'b0 ||
        bus.dbus_addr_out !== 32'h0 || bus.dbus_wdata_out !== 32'h0 || load_data !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_state: req=%b we=%b mask=%b vld=%b mis=%b err=%b stall=%b addr=%h wd=%h ld=%h exp all 0",
               bus.dbus_req_out, bus.dbus_we_out, bus.dbus_wmask_out, lvalid, misal, bus_err, stall,
               bus.dbus_addr_out, bus.dbus_wdata_out, load_data);
    end
    last_load = '0;
    reset_n = 1'b1;
  endtask

  task automatic test_directed();
    do_txn("word_load", 1, 0, 32'h100, 32'h0, 2'd2, 0, 3, 32'hDEADBEEF);
    do_txn("byte_load_s", 1, 0, 32'h203, 32'h0, 2'd0, 0, 1, 32'h80112233);
    do_txn("byte_load_u", 1, 0, 32'h203, 32'h0, 2'd0, 1, 2, 32'h80112233);
    do_txn("half_store", 0, 1, 32'h302, 32'h0000ABCD, 2'd1, 0, 1, 32'h0);
    do_txn("half_load_s", 1, 0, 32'h402, 32'h0, 2'd1, 0, 1, 32'h9ABC1234);
  endtask

  task automatic test_misaligned();
    do_txn("mis_word", 1, 0, 32'h101, 32'h0, 2'd2, 0, 1, 32'h0);
    do_txn("mis_half", 0, 1, 32'h105, 32'h1234, 2'd1, 0, 1, 32'h0);
    do_txn("after_mis", 1, 0, 32'h104, 32'h0, 2'd2, 0, 2, 32'h13579BDF);
  endtask

  task automatic test_simultaneous();
    do_txn("ld_st_both", 1, 1, 32'h601, 32'h000000A5, 2'd0, 0, 2, 32'hFFFFFFFF);
  endtask

  task automatic test_ack_idle();
    @(posedge clk); #1;
    bus.dbus_ack_in = 1'b1; bus.dbus_rdata_in = $urandom;
    #1;
    n_tests++;
    if (stall !== 1'b0) begin
      n_fail++;
      $display("FAIL ack_idle stall: got %b exp 0", stall);
    end
    @(posedge clk); #1;
    bus.dbus_ack_in = 1'b0;
    #1;
    n_tests++;
    if (lvalid !== 1'b0 || bus.dbus_req_out !== 1'b0 || load_data !== last_load) begin
      n_fail++;
      $display("FAIL ack_idle result: vld=%b req=%b ld=%h exp 0/0/%h", lvalid, bus.dbus_req_out, load_data, last_load);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] r;
    r = $urandom;
    @(posedge clk); #1;
    ld_req = 1'b1; addr = 32'h100; size = 2'd2; luns = 1'b0;
    @(posedge clk); #1;
    ld_req = 1'b0; bus.dbus_ack_in = 1'b1; bus.dbus_rdata_in = r;
    @(posedge clk); #1;
    bus.dbus_ack_in = 1'b0;
    st_req = 1'b1; addr = 32'h302; st_data = 32'h0000ABCD; size = 2'd1;
    #1;
    last_load = r;
    n_tests++;
    if (lvalid !== 1'b1 || load_data !== r || stall !== 1'b1 || bus.dbus_req_out !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b k+1: vld=%b ld=%h stall=%b req=%b exp 1/%h/1/0", lvalid, load_data, stall, bus.dbus_req_out, r);
    end
    @(posedge clk); #1;
    st_req = 1'b0; bus.dbus_ack_in = 1'b1;
    #1;
    n_tests++;
    if (bus.dbus_req_out !== 1'b1 || bus.dbus_we_out !== 1'b1 || bus.dbus_addr_out !== 32'h300 ||
        bus.dbus_wmask_out !== 4'b1100 || bus.dbus_wdata_out !== 32'hABCDABCD) begin
      n_fail++;
      $display("FAIL b2b store: req=%b we=%b addr=%h mask=%b wd=%h exp 1/1/300/1100/abcdabcd",
               bus.dbus_req_out, bus.dbus_we_out, bus.dbus_addr_out, bus.dbus_wmask_out, bus.dbus_wdata_out);
    end
    @(posedge clk); #1;
    bus.dbus_ack_in = 1'b0;
    #1;
    n_tests++;
    if (bus.dbus_req_out !== 1'b0 || lvalid !== 1'b0 || load_data !== last_load) begin
      n_fail++;
      $display("FAIL b2b end: req=%b vld=%b ld=%h exp 0/0/%h", bus.dbus_req_out, lvalid, load_data, last_load);
    end
  endtask

  task automatic test_reset_mid_req();
    @(posedge clk); #1;
    ld_req = 1'b1; addr = 32'h400; size = 2'd2;
    @(posedge clk); #1;
    ld_req = 1'b0;
    #1;
    n_tests++;
    if (bus.dbus_req_out !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid req before: got %b exp 1", bus.dbus_req_out);
    end
    @(posedge clk); #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    #1;
    last_load = '0;
    n_tests++;
    if (bus.dbus_req_out !== 1'b0 || lvalid !== 1'b0 || misal !== 1'b0 || bus_err !== 1'b0 || stall !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid after: req=%b vld=%b mis=%b err=%b stall=%b exp all 0",
               bus.dbus_req_out, lvalid, misal, bus_err, stall);
    end
    reset_n = 1'b1;
    do_txn("after_rst", 1, 0, 32'h404, 32'h0, 2'd2, 0, 1, 32'hCAFEF00D);
  endtask

  task automatic test_timeout();
    @(posedge clk); #1;
    ld_req = 1'b1; addr = 32'h500; size = 2'd2; bus.dbus_ack_in = 1'b0;
`ifdef MSRV32_DBUS_TIMEOUT_EN
    for (int j = 1; j <= TO; j++) begin
      @(posedge clk); #1;
      ld_req = 1'b0;
      #1;
      n_tests++;
      if (bus.dbus_req_out !== 1'b1 || stall !== 1'b1 || bus_err !== 1'b0) begin
        n_fail++;
        $display("FAIL timeout wait c%0d: req=%b stall=%b err=%b exp 1/1/0", j, bus.dbus_req_out, stall, bus_err);
      end
    end
    @(posedge clk); #2;
    n_tests++;
    if (bus.dbus_req_out !== 1'b0 || bus_err !== 1'b1 || stall !== 1'b0 || lvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout abort: req=%b err=%b stall=%b vld=%b exp 0/1/0/0", bus.dbus_req_out, bus_err, stall, lvalid);
    end
    @(posedge clk); #1;
    bus.dbus_ack_in = 1'b1;
    #1;
    n_tests++;
    if (bus_err !== 1'b0 || stall !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout err width: err=%b stall=%b exp 0/0", bus_err, stall);
    end
    @(posedge clk); #1;
    bus.dbus_ack_in = 1'b0;
    #1;
    n_tests++;
    if (lvalid !== 1'b0 || bus.dbus_req_out !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout late ack: vld=%b req=%b exp 0/0", lvalid, bus.dbus_req_out);
    end
`else
    for (int j = 1; j <= 20; j++) begin
      @(posedge clk); #1;
      ld_req = 1'b0;
      #1;
      n_tests++;
      if (bus.dbus_req_out !== 1'b1 || stall !== 1'b1 || bus_err !== 1'b0) begin
        n_fail++;
        $display("FAIL long wait c%0d: req=%b stall=%b err=%b exp 1/1/0", j, bus.dbus_req_out, stall, bus_err);
      end
    end
    @(posedge clk); #1;
    bus.dbus_ack_in = 1'b1; bus.dbus_rdata_in = 32'h0BADC0DE;
    @(posedge clk); #1;
    bus.dbus_ack_in = 1'b0;
    #1;
    last_load = 32'h0BADC0DE;
    n_tests++;
    if (lvalid !== 1'b1 || load_data !== last_load || bus_err !== 1'b0) begin
      n_fail++;
      $display("FAIL long wait done: vld=%b ld=%h err=%b exp 1/%h/0", lvalid, load_data, bus_err, last_load);
    end
`endif
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [1:0]  sz;
    logic        ld;
    logic        st;
    for (int i = 0; i < 40; i++) begin
      sz = 2'($urandom);
      a  = $urandom;
      st = 1'($urandom);
      ld = !st || ($urandom_range(0, 3) == 0);
      do_txn("random", ld, st, a, $urandom, sz, 1'($urandom), $urandom_range(1, 4), $urandom);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_misaligned();
    test_simultaneous();
    test_ack_idle();
    test_back_to_back();
    test_reset_mid_req();
    test_timeout();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/msrv32_lsu_ctrl.md
Name: msrv32_lsu_ctrl

Overview:
Load/store bus controller directly downstream of the decode→execute pipeline register. Takes the registered effective address (iadder), rs2 store data, load size and load-unsigned flag. Runs a request/acknowledge transaction on the data bus and stalls the pipeline until the transaction completes. Returns byte/half/word load data, aligned and sign- or zero-extended, to the writeback mux.

Parameters:
TIMEOUT_CYCLES, 256, cycles in REQ without ack before abort (used only with MSRV32_DBUS_TIMEOUT_EN)
CNT_W, 9, width of the timeout counter; must hold TIMEOUT_CYCLES

Ports:
clk_in  input  1  clock; all state on rising edge
reset_in  input  1  reset, synchronous, active-low (0 = reset)
ld_req_in  input  1  load request from pipeline register
st_req_in  input  1  store request from pipeline register
addr_in  input  32  effective byte address (iadder_out_reg_out)
st_data_in  input  32  store data (rs2_reg_out)
size_in  input  2  00 byte, 01 half, 10/11 word
load_unsigned_in  input  1  1 = zero-extend load, 0 = sign-extend
dbus_req_out  output  1  bus request, held until ack
dbus_we_out  output  1  1 = write
dbus_addr_out  output  32  word-aligned address {addr[31:2],2'b00}
dbus_wdata_out  output  32  lane-replicated store data
dbus_wmask_out  output  4  byte-lane write enables (0000 on loads)
dbus_ack_in  input  1  transaction complete; read data valid this cycle
dbus_rdata_in  input  32  read data
stall_out  output  1  pipeline hold
load_data_out  output  32  aligned, extended load result
load_valid_out  output  1  one-cycle pulse; load_data_out valid
misaligned_out  output  1  one-cycle pulse; access rejected
bus_err_out  output  1  one-cycle pulse; timeout abort

Behaviour:
- States: IDLE, REQ. On reset: IDLE; all registered outputs 0; counter 0.
- Misalignment check in IDLE: half with addr[0]=1, or word with addr[1:0]!=00.
  - Result: no bus transaction; misaligned_out=1 next cycle for 1 cycle; remain IDLE; no stall in the following cycle.
- Accept in IDLE, (ld_req_in|st_req_in) and aligned:
  - Latch the bus address, we=st_req_in, byte offset addr[1:0], size and unsigned flag.
  - Go to REQ. dbus_req_out=1 from the next cycle.
- Simultaneous ld_req_in and st_req_in: treat as a store; no load_valid_out.
- Store data:
  - byte → {4{d[7:0]}}, mask 0001<<off
  - half → {2{d[15:0]}}, mask 0011<<off
  - word → d, mask 1111
- REQ:
  - Hold dbus_req/we/addr/wdata/wmask stable until dbus_ack_in=1.
  - On ack: dbus_req_out=0 next cycle; return to IDLE.
  - For a load, the next cycle: load_data_out = extracted lane, extended; load_valid_out=1 for 1 cycle.
- Load extraction:
  - byte = rdata[8*off +: 8]
  - half = rdata[8*off +: 16] (off ∈ {0,2})
  - word = rdata
  - Extend to 32 bits using bit 7 or bit 15 per load_unsigned.
- load_data_out holds its last value until the next completed load.
- stall_out = (state==IDLE & (ld_req_in|st_req_in) & aligned) | (state==REQ & !dbus_ack_in). This is combinational.
- Latency: request seen in cycle 0; dbus_req_out is 1 in cycles 1..k; ack arrives in cycle k≥1; stall_out is 1 in cycles 0..k-1.
  - For a load, load_valid_out is 1 in cycle k+1.
  - A new request may be accepted in cycle k+1.
- dbus_ack_in while in IDLE: ignored.
- Reset asserted mid-REQ: next edge forces IDLE and dbus_req_out=0. No load_valid_out, misaligned_out or bus_err_out pulse.

Optional Feature:
MSRV32_DBUS_TIMEOUT_EN
- Defined:
  - The counter clears on entry to REQ and increments each REQ cycle without ack.
  - When the count reaches TIMEOUT_CYCLES: drop dbus_req_out, go IDLE, pulse bus_err_out for 1 cycle, no load_valid_out.
  - A late ack arriving in IDLE is ignored.
- Not defined: REQ waits indefinitely; bus_err_out is tied 0; the counter is not built.

Test Plan:
- Word load, addr=0x100, ack after 3 cycles, rdata=0xDEADBEEF → dbus_addr=0x100, wmask=0000, stall for 3 cycles, load_valid with load_data=0xDEADBEEF.
- Signed byte load, addr=0x203, rdata=0x80112233 → load_data=0xFFFFFF80. Same with load_unsigned=1 → 0x00000080.
- Half store, addr=0x302, st_data=0x0000ABCD, ack 1 cycle later → dbus_addr=0x300, wdata=0xABCDABCD, wmask=1100, we=1, no load_valid.
- Word load at addr=0x101 → misaligned_out pulse, dbus_req_out stays 0, stall_out 0. A following aligned request is accepted normally.
- Reset_in=0 during REQ with no ack → dbus_req_out=0 after the edge. After release, a fresh load with immediate ack completes correctly.
- With MSRV32_DBUS_TIMEOUT_EN and TIMEOUT_CYCLES=4, ack never asserted → bus_err_out pulses after 4 REQ cycles, stall_out drops, no load_valid.
